// File: rtl/disp_sched.sv
// Display scheduler: picks clock/alarm source, blinks the edited field and
// time-shares the display with a transient overlay. Optional macro: DISP_SEP_BLINK_EN.
module disp_sched #(
    parameter int BLINK_HALF = 500,
    parameter int OVR_TICKS  = 2000,
    parameter int CNT_W      = 16
) (
    input  logic        rst_n,
    input  logic        gen_clk,
    input  logic        i_src_sel,
    input  logic [41:0] i_clk_seg,
    input  logic [5:0]  i_clk_dp,
    input  logic [41:0] i_alm_seg,
    input  logic [5:0]  i_alm_dp,
    input  logic        i_edit_en,
    input  logic [1:0]  i_edit_pos,
    input  logic        i_ovr_req,
    input  logic [41:0] i_ovr_seg,
    output logic        o_ovr_ack,
    output logic        o_ovr_busy,
    output logic [1:0]  o_state,
    output logic [41:0] o_six_digit_seg,
    output logic [5:0]  o_six_dp
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_EDIT   = 2'd1,
        ST_OVR    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] OVR_LAST   = CNT_W'(OVR_TICKS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [CNT_W-1:0]   ovr_cnt_q, ovr_cnt_d;
    logic [41:0]        ovr_lat_q, ovr_lat_d;
    logic [1:0]         pos_q;
    logic [41:0]        seg_q, seg_d;
    logic [5:0]         dp_q, dp_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               accept;
    logic               blink_restart;
    logic [41:0]        src_seg;
    logic [5:0]         src_dp;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                if (i_ovr_req) begin
                    state_d = ST_OVR;
                    accept  = 1'b1;
                end else if (i_edit_en) begin
                    state_d = ST_EDIT;
                end
            end
            ST_EDIT: begin
                if (i_ovr_req) begin
                    state_d = ST_OVR;
                    accept  = 1'b1;
                end else if (!i_edit_en) begin
                    state_d = ST_NORMAL;
                end
            end
            ST_OVR: begin
                // Requests are ignored here; leaving always passes through NORMAL/EDIT.
                if (ovr_cnt_q == OVR_LAST) begin
                    state_d = i_edit_en ? ST_EDIT : ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        ovr_lat_d = ovr_lat_q;
        if (accept) begin
            ovr_cnt_d = '0;
            ovr_lat_d = i_ovr_seg;
        end else if (state_q == ST_OVR) begin
            ovr_cnt_d = (ovr_cnt_q == OVR_LAST) ? '0 : ovr_cnt_q + CNT_W'(1);
        end
    end

    // A freshly selected field must start visible so the user sees what was picked.
    assign blink_restart = ((state_q == ST_NORMAL) && (state_d == ST_EDIT)) ||
                           ((state_q == ST_EDIT) && (i_edit_pos != pos_q));

    always_comb begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
        blink_on_d  = blink_on_q;
        if (blink_restart) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end
    end

    assign src_seg = i_src_sel ? i_alm_seg : i_clk_seg;
    assign src_dp  = i_src_sel ? i_alm_dp  : i_clk_dp;

    // Output image is built from next-state values so it lines up with o_state.
    always_comb begin
        seg_d  = src_seg;
        dp_d   = src_dp;
        ack_d  = accept;
        busy_d = (state_d == ST_OVR);
        case (state_d)
            ST_EDIT: begin
                if (!blink_on_d) begin
                    case (i_edit_pos)
                        2'd0: begin
                            seg_d[13:0] = '0;
                            dp_d[1:0]   = '0;
                        end
                        2'd1: begin
                            seg_d[27:14] = '0;
                            dp_d[3:2]    = '0;
                        end
                        2'd2: begin
                            seg_d[41:28] = '0;
                            dp_d[5:4]    = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_OVR: begin
                seg_d = ovr_lat_d;
                dp_d  = '0;
            end
`ifdef DISP_SEP_BLINK_EN
            ST_NORMAL: begin
                if (!i_src_sel) begin
                    dp_d[2] = blink_on_d;
                    dp_d[4] = blink_on_d;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge gen_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_NORMAL;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            ovr_cnt_q   <= '0;
            ovr_lat_q   <= '0;
            pos_q       <= 2'd0;
            seg_q       <= '0;
            dp_q        <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            ovr_cnt_q   <= ovr_cnt_d;
            ovr_lat_q   <= ovr_lat_d;
            pos_q       <= i_edit_pos;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
        end
    end

    assign o_state         = state_q;
    assign o_six_digit_seg = seg_q;
    assign o_six_dp        = dp_q;
    assign o_ovr_ack       = ack_q;
    assign o_ovr_busy      = busy_q;

endmodule

// File: tb/tb_disp_sched.sv
// Directed scoreboard bench for disp_sched with short blink/overlay periods.
module tb_disp_sched;

    typedef struct packed {
        logic [41:0] seg;
        logic [5:0]  dp;
        logic [1:0]  st;
        logic        ack;
        logic        busy;
    } exp_t;

    localparam logic [41:0] ONES   = 42'h3FF_FFFF_FFFF;
    localparam logic [41:0] BLANK1 = 42'h3FF_F000_3FFF;
    localparam logic [41:0] BLANK2 = 42'h000_0FFF_FFFF;
    localparam logic [41:0] SEG_A  = 42'h123_4567_89AB;
    localparam logic [41:0] SEG_B  = 42'h0FE_DCBA_9876;
    localparam logic [41:0] PAT    = 42'h155_5555_5555;
    localparam logic [41:0] PAT2   = 42'h2AA_AAAA_AAAA;

    logic        rst_n;
    logic        gen_clk;
    logic        i_src_sel;
    logic [41:0] i_clk_seg;
    logic [5:0]  i_clk_dp;
    logic [41:0] i_alm_seg;
    logic [5:0]  i_alm_dp;
    logic        i_edit_en;
    logic [1:0]  i_edit_pos;
    logic        i_ovr_req;
    logic [41:0] i_ovr_seg;
    logic        o_ovr_ack;
    logic        o_ovr_busy;
    logic [1:0]  o_state;
    logic [41:0] o_six_digit_seg;
    logic [5:0]  o_six_dp;

    exp_t  sbQ[$];
    string tagQ[$];
    int    checks = 0;
    int    failures = 0;
    int    sinceReset = 0;

    disp_sched #(.BLINK_HALF(4), .OVR_TICKS(10), .CNT_W(16)) dut (
        .rst_n(rst_n),
        .gen_clk(gen_clk),
        .i_src_sel(i_src_sel),
        .i_clk_seg(i_clk_seg),
        .i_clk_dp(i_clk_dp),
        .i_alm_seg(i_alm_seg),
        .i_alm_dp(i_alm_dp),
        .i_edit_en(i_edit_en),
        .i_edit_pos(i_edit_pos),
        .i_ovr_req(i_ovr_req),
        .i_ovr_seg(i_ovr_seg),
        .o_ovr_ack(o_ovr_ack),
        .o_ovr_busy(o_ovr_busy),
        .o_state(o_state),
        .o_six_digit_seg(o_six_digit_seg),
        .o_six_dp(o_six_dp)
    );

    initial gen_clk = 1'b0;
    always #5 gen_clk = ~gen_clk;

    // Separator DPs under the optional macro follow the blink phase counted from reset.
    function automatic logic [5:0] sepDp(input logic [5:0] dp, input int k);
        logic on;
        on = ((k / 4) % 2) == 0;
`ifdef DISP_SEP_BLINK_EN
        return {dp[5], on, dp[3], on, dp[1:0]};
`else
        if (on) return dp;
        return dp;
`endif
    endfunction

    task automatic compareNow(input string tag, input exp_t e);
        exp_t obs;
        obs = {o_six_digit_seg, o_six_dp, o_state, o_ovr_ack, o_ovr_busy};
        checks++;
        assert (obs === e) else begin
            failures++;
            $display("FAIL %s observed seg=%h dp=%h st=%0d ack=%b busy=%b expected seg=%h dp=%h st=%0d ack=%b busy=%b",
                     tag, obs.seg, obs.dp, obs.st, obs.ack, obs.busy, e.seg, e.dp, e.st, e.ack, e.busy);
            $error("[TB] %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic checkOutput();
        exp_t  e;
        string tag;
        if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e   = sbQ.pop_front();
            tag = tagQ.pop_front();
            compareNow(tag, e);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [41:0] seg, input logic [5:0] dp,
                                 input logic [1:0] st, input logic ack, input logic busy);
        exp_t e;
        e.seg  = seg;
        e.dp   = dp;
        e.st   = st;
        e.ack  = ack;
        e.busy = busy;
        sbQ.push_back(e);
        tagQ.push_back(tag);
        @(posedge gen_clk);
        #1;
        sinceReset++;
        checkOutput();
    endtask

    initial begin
        exp_t zero;
        zero = '0;
        rst_n = 1'b0;
        i_src_sel = 1'b0;
        i_clk_seg = '0;
        i_clk_dp = '0;
        i_alm_seg = '0;
        i_alm_dp = '0;
        i_edit_en = 1'b0;
        i_edit_pos = 2'd0;
        i_ovr_req = 1'b0;
        i_ovr_seg = '0;
        repeat (3) @(posedge gen_clk);
        #1;
        compareNow("reset_init", zero);

        // Source switching
        i_clk_seg = SEG_A; i_clk_dp = 6'h15;
        i_alm_seg = SEG_B; i_alm_dp = 6'h2A;
        rst_n = 1'b1;
        sinceReset = 0;
        applyStimulus("src_clk0", SEG_A, sepDp(6'h15, sinceReset + 1), 2'd0, 1'b0, 1'b0);
        applyStimulus("src_clk1", SEG_A, sepDp(6'h15, sinceReset + 1), 2'd0, 1'b0, 1'b0);
        i_src_sel = 1'b1;
        applyStimulus("src_alm", SEG_B, 6'h2A, 2'd0, 1'b0, 1'b0);
        i_src_sel = 1'b0;
        applyStimulus("src_back", SEG_A, sepDp(6'h15, sinceReset + 1), 2'd0, 1'b0, 1'b0);

        // Mid-run reset clears outputs immediately
        rst_n = 1'b0;
        #1;
        compareNow("reset_async", zero);
        i_clk_seg = ONES;
        i_clk_dp = 6'h00;
        @(posedge gen_clk);
        #1;
        compareNow("reset_held", zero);
        rst_n = 1'b1;
        sinceReset = 0;
        applyStimulus("reset_release", ONES, sepDp(6'h00, sinceReset + 1), 2'd0, 1'b0, 1'b0);

        // Separator DPs in NORMAL with clock source
        for (int i = 0; i < 8; i++) begin
            applyStimulus("sep_dp", ONES, sepDp(6'h00, sinceReset + 1), 2'd0, 1'b0, 1'b0);
        end

        // Edit blink on minutes, then hours
        i_clk_dp = 6'h3F;
        i_edit_en = 1'b1;
        i_edit_pos = 2'd1;
        for (int i = 0; i < 4; i++) applyStimulus("edit1_on", ONES, 6'h3F, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus("edit1_off", BLANK1, 6'h33, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus("edit1_on2", ONES, 6'h3F, 2'd1, 1'b0, 1'b0);
        i_edit_pos = 2'd2;
        for (int i = 0; i < 4; i++) applyStimulus("edit2_on", ONES, 6'h3F, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus("edit2_off", BLANK2, 6'h0F, 2'd1, 1'b0, 1'b0);
        applyStimulus("edit2_on2", ONES, 6'h3F, 2'd1, 1'b0, 1'b0);

        // Overlay from EDIT, held request gives a second ack after a gap
        i_edit_pos = 2'd3;
        applyStimulus("edit3", ONES, 6'h3F, 2'd1, 1'b0, 1'b0);
        i_ovr_req = 1'b1;
        i_ovr_seg = PAT;
        applyStimulus("ovr_ack", PAT, 6'h00, 2'd2, 1'b1, 1'b1);
        i_ovr_seg = '0;
        for (int i = 0; i < 9; i++) applyStimulus("ovr_hold", PAT, 6'h00, 2'd2, 1'b0, 1'b1);
        i_ovr_seg = PAT2;
        applyStimulus("ovr_gap", ONES, 6'h3F, 2'd1, 1'b0, 1'b0);
        applyStimulus("ovr_ack2", PAT2, 6'h00, 2'd2, 1'b1, 1'b1);
        i_ovr_req = 1'b0;
        i_src_sel = 1'b1;
        i_alm_seg = ONES;
        i_alm_dp = 6'h3F;
        for (int i = 0; i < 3; i++) applyStimulus("ovr2_hold", PAT2, 6'h00, 2'd2, 1'b0, 1'b1);
        i_edit_en = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus("ovr2_noedit", PAT2, 6'h00, 2'd2, 1'b0, 1'b1);
        applyStimulus("ovr2_normal", ONES, 6'h3F, 2'd0, 1'b0, 1'b0);

        // Overlay beats edit when both rise together
        rst_n = 1'b0;
        #1;
        compareNow("reset_prio", zero);
        i_src_sel = 1'b0;
        i_clk_seg = ONES;
        i_clk_dp = 6'h3F;
        i_edit_pos = 2'd3;
        @(posedge gen_clk);
        #1;
        rst_n = 1'b1;
        sinceReset = 0;
        i_edit_en = 1'b1;
        i_ovr_req = 1'b1;
        i_ovr_seg = PAT;
        applyStimulus("prio_ack", PAT, 6'h00, 2'd2, 1'b1, 1'b1);
        i_ovr_req = 1'b0;
        for (int i = 0; i < 9; i++) applyStimulus("prio_hold", PAT, 6'h00, 2'd2, 1'b0, 1'b1);
        applyStimulus("prio_edit", ONES, 6'h3F, 2'd1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_sched.md
Name: disp_sched

Overview:
- Display scheduler in front of the 6-digit multiplexed 7-segment driver. It produces the 42-bit segment bus and 6-bit DP bus that the scan driver consumes.
- Shares the display between two steady sources (clock time, alarm time) and one transient overlay requester (message/status).
- Blinks the field under edit during time setting.
- Runs on gen_clk, the display scan tick domain.

Parameters:
- BLINK_HALF, 500, gen_clk cycles per blink half-period; must be >= 2.
- OVR_TICKS, 2000, gen_clk cycles an accepted overlay stays on the display; must be >= 1.
- CNT_W, 16, width of the internal blink and overlay counters; must hold max(BLINK_HALF, OVR_TICKS).

Ports:
- rst_n  input  1  reset, asynchronous, active-low
- gen_clk  input  1  clock
- i_src_sel  input  1  0 = clock source, 1 = alarm source
- i_clk_seg  input  42  clock-source segments; [6:0] sec-right ... [41:35] hour-left
- i_clk_dp  input  6  clock-source DPs
- i_alm_seg  input  42  alarm-source segments
- i_alm_dp  input  6  alarm-source DPs
- i_edit_en  input  1  time-setting mode active
- i_edit_pos  input  2  field under edit: 0 sec, 1 min, 2 hour, 3 none
- i_ovr_req  input  1  overlay request; level, held until ack
- i_ovr_seg  input  42  overlay pattern; sampled on ack
- o_ovr_ack  output  1  one-cycle pulse: overlay accepted
- o_ovr_busy  output  1  overlay currently displayed
- o_state  output  2  0 NORMAL, 1 EDIT, 2 OVR
- o_six_digit_seg  output  42  to scan driver
- o_six_dp  output  6  to scan driver

Behaviour:
- Reset (async, rst_n=0) drives the following values:
  - State NORMAL, o_state=0.
  - o_six_digit_seg=42'd0 (all segments off), o_six_dp=6'd0.
  - o_ovr_ack=0, o_ovr_busy=0.
  - Blink counter 0, blink_on=1, overlay counter 0, overlay latch 0.
- All outputs are registered. Input-to-output latency is 1 gen_clk cycle.
- Source mux: src = i_src_sel ? alarm : clock. Segments and DPs are selected together.
- Blink: counter runs 0..BLINK_HALF-1 in every state; blink_on toggles on wrap.
  - Any change of i_edit_pos in EDIT, and the NORMAL->EDIT entry, clears the counter and sets blink_on=1.
- FSM:
  - NORMAL: i_ovr_req=1 -> OVR; else i_edit_en=1 -> EDIT. Output = src.
  - EDIT: i_ovr_req=1 -> OVR; else i_edit_en=0 -> NORMAL. Output = src with the edited field blanked while blink_on=0:
    - pos0 blanks seg[13:0] and dp[1:0].
    - pos1 blanks seg[27:14] and dp[3:2].
    - pos2 blanks seg[41:28] and dp[5:4].
    - pos3 blanks nothing.
  - OVR: o_ovr_busy=1; output = latched overlay, dp=0. Overlay counter counts 0..OVR_TICKS-1. On its final count:
    - -> EDIT if i_edit_en=1, else -> NORMAL.
    - o_ovr_busy drops in the same cycle the state leaves OVR.
- Acceptance: on the NORMAL/EDIT->OVR transition cycle:
  - o_ovr_ack pulses for exactly 1 cycle.
  - i_ovr_seg is latched.
  - The overlay counter is cleared.
- Overlay priority: overlay beats edit. i_ovr_req and i_edit_en both high in NORMAL -> OVR.
- i_ovr_req while in OVR is ignored; no ack, no restart.
- A request still high when OVR expires is accepted after at least 1 cycle in NORMAL/EDIT, giving a minimum 1-cycle gap between overlays.
- i_edit_en dropping during OVR has no effect until expiry.
- Reset mid-OVR aborts the overlay; the requester must re-request.

Optional Feature:
- Macro: DISP_SEP_BLINK_EN.
- Defined: in NORMAL with i_src_sel=0, o_six_dp[2] and o_six_dp[4] (min/hour separators) are driven by blink_on instead of i_clk_dp[2] and i_clk_dp[4]. EDIT and OVR are unchanged.
- Undefined: DPs pass through unmodified in every state; no extra logic.

Test Plan:
- All tests use BLINK_HALF=4 and OVR_TICKS=10.
- Reset: rst_n=0 mid-run -> all outputs 0 immediately, o_state=0. After release with i_clk_seg=42'h3FF_FFFF_FFFF, the output equals it 1 cycle later.
- Source switch: i_clk_seg=A, i_alm_seg=B, toggle i_src_sel 0->1 -> output A, then B 1 cycle after the toggle, with DPs following.
- Edit blink: i_edit_en=1, i_edit_pos=1, segments all 1s:
  - seg[27:14] alternates all-1s / 0 every 4 cycles; other bits stay 1s.
  - Changing pos to 2 -> seg[41:28] visible for the next 4 cycles, then blinking.
- Overlay: i_ovr_req=1 with i_ovr_seg=42'h155_5555_5555 while in EDIT:
  - 1 ack pulse, busy=1, output = pattern for exactly 10 cycles.
  - Then returns to EDIT with busy=0. Holding req high gives a second ack only after a 1-cycle gap.
- Priority: i_ovr_req and i_edit_en rise together in NORMAL -> o_state=2, then o_state=1 after 10 cycles.
- DISP_SEP_BLINK_EN defined, NORMAL, clock source, i_clk_dp=0 -> o_six_dp alternates 6'b010100 / 0 every 4 cycles. Macro undefined -> constant 0.
